// File: rtl/ym_sync_cells.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ym_sync_cells: MCLK-sampled clear-on-reset flop, set-on-reset flop and  |
// | level latch; every output shows the next-state value combinationally.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ym_sync_cells #(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  MCLK,
   input  logic                  reset,
   input  logic                  r_clk,
   input  logic [DATA_WIDTH-1:0] r_val,
   output logic [DATA_WIDTH-1:0] r_q,
   output logic [DATA_WIDTH-1:0] r_nq,
   input  logic                  s_clk,
   input  logic [DATA_WIDTH-1:0] s_val,
   output logic [DATA_WIDTH-1:0] s_q,
   output logic [DATA_WIDTH-1:0] s_nq,
   input  logic                  l_en,
   input  logic [DATA_WIDTH-1:0] l_inp,
   output logic [DATA_WIDTH-1:0] l_val,
   output logic [DATA_WIDTH-1:0] l_nval
);

   logic [DATA_WIDTH-1:0] mem_r_q, mem_r_d;
   logic [DATA_WIDTH-1:0] mem_s_q, mem_s_d;
   logic [DATA_WIDTH-1:0] mem_l_q, mem_l_d;
   logic                  clk_old_r_q, clk_old_r_d;
   logic                  clk_old_s_q, clk_old_s_d;
   logic                  w_edge_r;
   logic                  w_edge_s;

   // Edge trackers keep following their logical clock through reset, so an
   // edge seen while reset is high is consumed rather than deferred.
   always_comb begin
      w_edge_r    = ~clk_old_r_q & r_clk;
      w_edge_s    = ~clk_old_s_q & s_clk;
      clk_old_r_d = r_clk;
      clk_old_s_d = s_clk;

      mem_r_d = mem_r_q;
      if (reset)
         mem_r_d = '0;
      else if (w_edge_r)
         mem_r_d = r_val;

      mem_s_d = mem_s_q;
      if (reset)
         mem_s_d = '1;
      else if (w_edge_s)
         mem_s_d = s_val;

      mem_l_d = l_en ? l_inp : mem_l_q;
   end

   always_ff @(posedge MCLK) begin
      clk_old_r_q <= clk_old_r_d;
      clk_old_s_q <= clk_old_s_d;
      mem_l_q     <= mem_l_d;
      if (reset) begin
         mem_r_q <= '0;
         mem_s_q <= '1;
      end else begin
         mem_r_q <= mem_r_d;
         mem_s_q <= mem_s_d;
      end
   end

   assign r_q    = mem_r_d;
   assign r_nq   = ~mem_r_d;
   assign s_q    = mem_s_d;
   assign s_nq   = ~mem_s_d;
   assign l_val  = mem_l_d;
   assign l_nval = ~mem_l_d;

endmodule
`default_nettype wire

// File: tb/tb_ym_sync_cells.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ym_sync_cells: directed self-checking bench for ym_sync_cells, W=16.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ym_sync_cells;

   localparam int W = 16;

   logic         MCLK = 1'b0;
   logic         reset;
   logic         r_clk, s_clk, l_en;
   logic [W-1:0] r_val, s_val, l_inp;
   logic [W-1:0] r_q, r_nq, s_q, s_nq, l_val, l_nval;

   int checks = 0;
   int errors = 0;

   ym_sync_cells #(.DATA_WIDTH(W)) dut (
      .MCLK   (MCLK),
      .reset  (reset),
      .r_clk  (r_clk),
      .r_val  (r_val),
      .r_q    (r_q),
      .r_nq   (r_nq),
      .s_clk  (s_clk),
      .s_val  (s_val),
      .s_q    (s_q),
      .s_nq   (s_nq),
      .l_en   (l_en),
      .l_inp  (l_inp),
      .l_val  (l_val),
      .l_nval (l_nval)
   );

   always #5 MCLK = ~MCLK;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one MCLK rise, then leave a small gap before new stimulus.
   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   initial begin
      reset = 1'b1; r_clk = 1'b0; s_clk = 1'b0; l_en = 1'b0;
      r_val = '0; s_val = '0; l_inp = '0;

      // 1: reset for two MCLK
      tick(); tick();
      #1;
      chk("rst_r_q",  r_q,  16'h0000);
      chk("rst_s_q",  s_q,  16'hFFFF);
      chk("rst_r_nq", r_nq, 16'hFFFF);
      chk("rst_s_nq", s_nq, 16'h0000);

      // 2: capture visible in same cycle, level high ignored, re-capture
      reset = 1'b0; r_val = 16'h5345; r_clk = 1'b1;
      #1 chk("cap_same_cycle", r_q, 16'h5345);
      tick();
      r_val = 16'h1234;
      #1 chk("hold_level_high", r_q, 16'h5345);
      tick();
      r_clk = 1'b0; r_val = 16'h0BCD;
      #1 chk("fall_no_cap", r_q, 16'h5345);
      tick();
      r_clk = 1'b1;
      #1 chk("recapture", r_q, 16'h0BCD);
      chk("recapture_nq", r_nq, 16'hF432);
      tick();

      // 3: edge coincident with reset is consumed
      r_clk = 1'b0;
      tick();
      reset = 1'b1; r_clk = 1'b1; r_val = 16'hAAAA;
      #1 chk("rst_beats_edge", r_q, 16'h0000);
      tick();
      reset = 1'b0;
      #1 chk("no_late_cap", r_q, 16'h0000);
      tick();
      chk("no_late_cap_hold", r_q, 16'h0000);

      // 4: S flop capture of zero, then reset sets it
      s_val = 16'h0000; s_clk = 1'b1;
      #1 chk("s_cap_zero", s_q, 16'h0000);
      chk("s_cap_zero_nq", s_nq, 16'hFFFF);
      tick();
      chk("s_stored_zero", s_q, 16'h0000);
      reset = 1'b1;
      #1 chk("s_rst_immediate", s_q, 16'hFFFF);
      tick();
      reset = 1'b0;
      #1 chk("s_rst_held", s_q, 16'hFFFF);
      tick();
      chk("s_rst_held2", s_q, 16'hFFFF);
      s_clk = 1'b0;

      // 5: latch transparency, hold, reset immunity
      l_en = 1'b1; l_inp = 16'h4741;
      #1 chk("l_transparent", l_val, 16'h4741);
      chk("l_transparent_n", l_nval, 16'hB8BE);
      tick();
      l_en = 1'b0; l_inp = 16'h0000;
      #1 chk("l_hold", l_val, 16'h4741);
      reset = 1'b1;
      #1 chk("l_ignores_rst", l_val, 16'h4741);
      tick();
      chk("l_ignores_rst_reg", l_val, 16'h4741);
      chk("l_ignores_rst_n", l_nval, 16'hB8BE);
      reset = 1'b0;

      // 6: 1->0->1 across consecutive MCLK edges
      r_clk = 1'b0;
      tick();
      r_clk = 1'b1; r_val = 16'h0001;
      #1 chk("pulse1_q", r_q, 16'h0001);
      chk("pulse1_nq", r_nq, 16'hFFFE);
      tick();
      r_clk = 1'b0; r_val = 16'h0002;
      #1 chk("pulse_low_q", r_q, 16'h0001);
      chk("pulse_low_nq", r_nq, 16'hFFFE);
      tick();
      r_clk = 1'b1;
      #1 chk("pulse2_q", r_q, 16'h0002);
      chk("pulse2_nq", r_nq, 16'hFFFD);
      tick();
      chk("pulse2_reg_q", r_q, 16'h0002);
      chk("pulse2_reg_nq", r_nq, 16'hFFFD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
